// File: rtl/yarp_vmmul_seq.sv
// Sequential 4x4 signed matrix multiply over a vector register file: C[vd..] = A[vs1..] x B[vs2..].
// Define YARP_MMUL_SAT_EN for 66-bit accumulators with 32-bit saturation at writeback; otherwise wrap mod 2^32.
module yarp_vmmul_seq #(
    parameter int VECTOR_REG_WIDTH = 128,
    parameter int VECTOR_REG_COUNT = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start_i,
    input  logic [$clog2(VECTOR_REG_COUNT)-1:0] vd_i,
    input  logic [$clog2(VECTOR_REG_COUNT)-1:0] vs1_i,
    input  logic [$clog2(VECTOR_REG_COUNT)-1:0] vs2_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [$clog2(VECTOR_REG_COUNT)-1:0] vrf_rd_addr_o,
    input  logic [VECTOR_REG_WIDTH-1:0]         vrf_rd_data_i,
    output logic                                vrf_wr_en_o,
    output logic [$clog2(VECTOR_REG_COUNT)-1:0] vrf_wr_addr_o,
    output logic [VECTOR_REG_WIDTH-1:0]         vrf_wr_data_o
);
    localparam int AW = $clog2(VECTOR_REG_COUNT);
`ifdef YARP_MMUL_SAT_EN
    localparam int ACC_W = 66;
`else
    localparam int ACC_W = 32;
`endif

    typedef enum logic [2:0] {IDLE, LD_A, MAC, WB, DONE} state_t;
    state_t state, state_nxt;

    logic [AW-1:0]               vd_q, vs1_q, vs2_q;
    logic [1:0]                  i, k, w;
    logic [VECTOR_REG_WIDTH-1:0] a_row;
    logic signed [ACC_W-1:0]     acc [4][4];
    logic signed [ACC_W-1:0]     prod_ext [4];
    logic [31:0]                 a_elem;
    logic [VECTOR_REG_WIDTH-1:0] wb_row;
`ifdef YARP_MMUL_SAT_EN
    logic signed [63:0]          prod [4];
`endif

    function automatic logic [31:0] to_lane(input logic signed [ACC_W-1:0] v);
`ifdef YARP_MMUL_SAT_EN
        if ((&v[ACC_W-1:31]) || !(|v[ACC_W-1:31]))
            return v[31:0];
        return v[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        return v;
`endif
    endfunction

    // B row k arrives on the read port in the same MAC cycle; A[i][k] comes from the captured row
    always_comb begin
        a_elem = a_row[{k, 5'b0} +: 32];
        for (int unsigned j = 0; j < 4; j++) begin
`ifdef YARP_MMUL_SAT_EN
            prod[j]     = $signed(a_elem) * $signed(vrf_rd_data_i[32*j +: 32]);
            prod_ext[j] = {{(ACC_W-64){prod[j][63]}}, prod[j]};
`else
            prod_ext[j] = a_elem * vrf_rd_data_i[32*j +: 32];
`endif
        end
    end

    always_comb begin
        wb_row = '0;
        for (int unsigned j = 0; j < 4; j++)
            wb_row[32*j +: 32] = to_lane(acc[w][j]);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        vrf_rd_addr_o = '0;
        vrf_wr_en_o   = 1'b0;
        vrf_wr_addr_o = '0;
        vrf_wr_data_o = '0;
        case (state)
            IDLE: if (start_i) state_nxt = LD_A;
            LD_A: begin
                busy_o        = 1'b1;
                vrf_rd_addr_o = vs1_q + AW'(i);
                state_nxt     = MAC;
            end
            MAC: begin
                busy_o        = 1'b1;
                vrf_rd_addr_o = vs2_q + AW'(k);
                if (k == 2'd3) state_nxt = (i == 2'd3) ? WB : LD_A;
            end
            WB: begin
                busy_o        = 1'b1;
                vrf_wr_en_o   = 1'b1;
                vrf_wr_addr_o = vd_q + AW'(w);
                vrf_wr_data_o = wb_row;
                if (w == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vd_q  <= '0;
            vs1_q <= '0;
            vs2_q <= '0;
            i     <= '0;
            k     <= '0;
            w     <= '0;
            a_row <= '0;
            for (int unsigned r = 0; r < 4; r++)
                for (int unsigned j = 0; j < 4; j++)
                    acc[r][j] <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    vd_q  <= vd_i;
                    vs1_q <= vs1_i;
                    vs2_q <= vs2_i;
                    i     <= '0;
                    k     <= '0;
                    w     <= '0;
                    for (int unsigned r = 0; r < 4; r++)
                        for (int unsigned j = 0; j < 4; j++)
                            acc[r][j] <= '0;
                end
                LD_A: begin
                    a_row <= vrf_rd_data_i;
                    k     <= '0;
                end
                MAC: begin
                    for (int unsigned j = 0; j < 4; j++)
                        acc[i][j] <= acc[i][j] + prod_ext[j];
                    k <= k + 2'd1;
                    if (k == 2'd3) i <= i + 2'd1;
                end
                WB: w <= w + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_yarp_vmmul_seq.sv
// Scoreboard bench for yarp_vmmul_seq: directed matrix runs push expected VRF writes and done timing,
// a negedge monitor pops and compares whenever the DUT writes or signals done.
module tb_yarp_vmmul_seq;
    logic         clk = 1'b0;
    logic         reset, start_i;
    logic [4:0]   vd_i, vs1_i, vs2_i;
    logic         busy_o, done_o;
    logic [4:0]   vrf_rd_addr_o, vrf_wr_addr_o;
    logic [127:0] vrf_rd_data_i, vrf_wr_data_o;
    logic         vrf_wr_en_o;

    always #5 clk = ~clk;

    yarp_vmmul_seq #(.VECTOR_REG_WIDTH(128), .VECTOR_REG_COUNT(32)) dut (
        .clk(clk), .reset(reset), .start_i(start_i),
        .vd_i(vd_i), .vs1_i(vs1_i), .vs2_i(vs2_i),
        .busy_o(busy_o), .done_o(done_o),
        .vrf_rd_addr_o(vrf_rd_addr_o), .vrf_rd_data_i(vrf_rd_data_i),
        .vrf_wr_en_o(vrf_wr_en_o), .vrf_wr_addr_o(vrf_wr_addr_o), .vrf_wr_data_o(vrf_wr_data_o)
    );

    // VRF model: combinational read, bench preload port takes priority over DUT writes
    logic [127:0] vrf [32];
    logic         tb_we = 1'b0;
    logic [4:0]   tb_waddr = '0;
    logic [127:0] tb_wdata = '0;
    assign vrf_rd_data_i = vrf[vrf_rd_addr_o];
    always @(posedge clk) begin
        if (tb_we)            vrf[tb_waddr] <= tb_wdata;
        else if (vrf_wr_en_o) vrf[vrf_wr_addr_o] <= vrf_wr_data_o;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endfunction

    typedef struct {
        int           cyc;
        logic [4:0]   addr;
        logic [127:0] data;
    } wr_t;
    wr_t          wr_q[$];
    int           done_q[$];
    logic [127:0] exp_c [4];

    function automatic logic [127:0] row(input int e0, input int e1, input int e2, input int e3);
        return {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
    endfunction

    always @(negedge clk) begin
        if (vrf_wr_en_o) begin
            if (wr_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got write to v%0d data %h at cycle %0d, required none",
                         vrf_wr_addr_o, vrf_wr_data_o, cyc);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_addr", 128'(vrf_wr_addr_o), 128'(e.addr));
                chk("wr_data", vrf_wr_data_o, e.data);
                chk("wr_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
        if (done_o) begin
            if (done_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done_o at cycle %0d, required none", cyc);
            end else begin
                int d;
                d = done_q.pop_front();
                chk("done_cycle", 128'(cyc), 128'(d));
            end
        end
    end

    task automatic load(input logic [4:0] a, input logic [127:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Start pulse in cycle 0 (s); writes expected in cycles s+21..s+24, done in s+25
    task automatic run(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                       input bit expect_result, output int s);
        @(negedge clk);
        s = cyc;
        if (expect_result) begin
            for (int w = 0; w < 4; w++)
                wr_q.push_back('{cyc: s + 21 + w, addr: vd + 5'(w), data: exp_c[w]});
            done_q.push_back(s + 25);
        end
        start_i = 1'b1; vd_i = vd; vs1_i = vs1; vs2_i = vs2;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic drain();
        repeat (32) @(negedge clk);
        chk("pending_writes", 128'(wr_q.size()), 128'(0));
        chk("pending_done", 128'(done_q.size()), 128'(0));
    endtask

    task automatic load_b(input logic [4:0] base);
        load(base,        row(1, 2, 3, 4));
        load(base + 5'd1, row(5, 6, 7, 8));
        load(base + 5'd2, row(9, 10, 11, 12));
        load(base + 5'd3, row(13, 14, 15, 16));
    endtask

    task automatic load_identity(input logic [4:0] base);
        load(base,        row(1, 0, 0, 0));
        load(base + 5'd1, row(0, 1, 0, 0));
        load(base + 5'd2, row(0, 0, 1, 0));
        load(base + 5'd3, row(0, 0, 0, 1));
    endtask

    task automatic fill(input logic [4:0] base, input int v);
        for (int r = 0; r < 4; r++) load(base + 5'(r), row(v, v, v, v));
    endtask

    int s;

    initial begin
        reset = 1'b1; start_i = 1'b0; vd_i = '0; vs1_i = '0; vs2_i = '0;
        repeat (2) @(negedge clk);
        start_i = 1'b1;  // start coincident with reset must be ignored
        @(negedge clk);
        reset = 1'b0; start_i = 1'b0;
        @(negedge clk);
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_done", 128'(done_o), 128'(0));
        chk("rst_wr_en", 128'(vrf_wr_en_o), 128'(0));
        chk("rst_rd_addr", 128'(vrf_rd_addr_o), 128'(0));
        chk("rst_wr_addr", 128'(vrf_wr_addr_o), 128'(0));
        chk("rst_wr_data", vrf_wr_data_o, 128'(0));

        // Identity: C = B
        load_identity(5'd1);
        load_b(5'd5);
        for (int r = 0; r < 4; r++) exp_c[r] = row(4*r + 1, 4*r + 2, 4*r + 3, 4*r + 4);
        run(5'd10, 5'd1, 5'd5, 1'b1, s);
        drain();

        // All 2 x all 3: each element 4*6 = 24
        fill(5'd16, 2);
        fill(5'd20, 3);
        for (int r = 0; r < 4; r++) exp_c[r] = row(24, 24, 24, 24);
        run(5'd24, 5'd16, 5'd20, 1'b1, s);
        drain();

        // 4 x (0x7FFFFFFF*2) = 0x3_FFFFFFF8: low word wraps, saturated build clamps
        fill(5'd14, 32'h7FFF_FFFF);
        fill(5'd20, 2);
`ifdef YARP_MMUL_SAT_EN
        for (int r = 0; r < 4; r++) exp_c[r] = row(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
`else
        for (int r = 0; r < 4; r++) exp_c[r] = row(32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
`endif
        run(5'd26, 5'd14, 5'd20, 1'b1, s);
        drain();

        // vd = vs1 = 30 wrapping through v0/v1; A has a negative entry
        load(5'd30, row(1, 2, 0, 0));
        load(5'd31, row(0, 1, 0, 0));
        load(5'd0,  row(0, 0, 3, 0));
        load(5'd1,  row(1, 0, 0, -1));
        load_b(5'd4);
        exp_c[0] = row(11, 14, 17, 20);
        exp_c[1] = row(5, 6, 7, 8);
        exp_c[2] = row(27, 30, 33, 36);
        exp_c[3] = row(-12, -12, -12, -12);
        run(5'd30, 5'd30, 5'd4, 1'b1, s);
        drain();

        // Extra starts while busy (cycle 5) and in DONE (cycle 25) are ignored
        load_identity(5'd1);
        load_b(5'd5);
        for (int r = 0; r < 4; r++) exp_c[r] = row(4*r + 1, 4*r + 2, 4*r + 3, 4*r + 4);
        run(5'd10, 5'd1, 5'd5, 1'b1, s);
        while (cyc < s + 5) @(negedge clk);
        start_i = 1'b1; vd_i = 5'd20; vs1_i = 5'd5; vs2_i = 5'd5;
        @(negedge clk);
        start_i = 1'b0;
        while (cyc < s + 25) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        drain();

        // Reset in cycle 10 aborts: no writes, no done
        fill(5'd16, 2);
        fill(5'd20, 3);
        run(5'd24, 5'd16, 5'd20, 1'b0, s);
        while (cyc < s + 10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 128'(busy_o), 128'(0));
        chk("abort_rd_addr", 128'(vrf_rd_addr_o), 128'(0));
        drain();

        // Normal run after abort
        for (int r = 0; r < 4; r++) exp_c[r] = row(24, 24, 24, 24);
        run(5'd8, 5'd16, 5'd20, 1'b1, s);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
